int_tx: RTL and testbench



---
 rtl/int_tx_pkg.sv | 26 ++
 rtl/int_tx_if.sv | 25 ++
 rtl/int_tx_dec.sv | 22 ++
 rtl/int_tx.sv | 131 +++++++++++++
 tb/tb_int_tx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/int_tx_pkg.sv
// Shared definitions for the integer-to-ASCII transmitter: FSM state
// encodings, ASCII constants and the decimal divisors.
package int_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_H   = 3'd1,
    CONV_T   = 3'd2,
    SEND_H   = 3'd3,
    SEND_T   = 3'd4,
    SEND_U   = 3'd5,
    SEND_LF  = 3'd6,
    WAIT_REL = 3'd7
  } state_t;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] DIV_HUNDREDS = 8'd100;
  localparam logic [7:0] DIV_TENS     = 8'd10;

  // Map a decimal digit count onto its ASCII character (8-bit wrap).
  function automatic logic [7:0] to_ascii(input logic [7:0] digit);
    return ASCII_ZERO + digit;
  endfunction

endpackage

// File: rtl/int_tx_if.sv
// Request/FIFO-side signal bundle of int_tx. The master side is the
// transmitter; the slave side is the requester plus the TX FIFO.
interface int_tx_if;
  logic       enviar;
  logic       fifo_full;
  logic [7:0] DATO_ALU;
  logic       WR_FIFO;
  logic [7:0] data_fifo;

  modport master (
    input  enviar,
    input  fifo_full,
    input  DATO_ALU,
    output WR_FIFO,
    output data_fifo
  );

  modport slave (
    output enviar,
    output fifo_full,
    output DATO_ALU,
    input  WR_FIFO,
    input  data_fifo
  );
endinterface

// File: rtl/int_tx_dec.sv
// Subtractive binary-to-decimal step unit: for the current working value
// it reports whether another hundred/ten can be taken out and the
// remainder that results. The caller performs one step per cycle.
module int_tx_dec
  import int_tx_pkg::*;
(
  input  logic [7:0] value,
  output logic       ge_hundred,
  output logic [7:0] rem_hundred,
  output logic       ge_ten,
  output logic [7:0] rem_ten
);

  // Compare and subtract for both digit positions in parallel.
  always_comb begin
    ge_hundred  = (value >= DIV_HUNDREDS);
    rem_hundred = value - DIV_HUNDREDS;
    ge_ten      = (value >= DIV_TENS);
    rem_ten     = value - DIV_TENS;
  end

endmodule

// File: rtl/int_tx.sv
// Integer transmitter: latches an 8-bit value on a send request, converts
// it to three ASCII decimal digits by repeated subtraction, and writes the
// digits followed by a line feed into a TX FIFO, honouring fifo_full.
module int_tx
  import int_tx_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  int_tx_if.master   bus,
  output logic [2:0] STATE,
  output logic [7:0] AUX,
  output logic [7:0] I,
  output logic [7:0] J
);

  state_t     state;
  state_t     state_n;
  logic [7:0] aux_n;
  logic [7:0] i_n;
  logic [7:0] j_n;
  logic       wr_n;
  logic [7:0] data_n;

  logic       ge_hundred;
  logic [7:0] rem_hundred;
  logic       ge_ten;
  logic [7:0] rem_ten;

  int_tx_dec u_dec (
    .value       (AUX),
    .ge_hundred  (ge_hundred),
    .rem_hundred (rem_hundred),
    .ge_ten      (ge_ten),
    .rem_ten     (rem_ten)
  );

  assign STATE = state;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, conversion datapath and write strobe; the strobe defaults
  // low so it is only high for the single edge that issues a byte.
  always_comb begin
    state_n = state;
    aux_n   = AUX;
    i_n     = I;
    j_n     = J;
    wr_n    = 1'b0;
    data_n  = bus.data_fifo;
    case (state)
      IDLE: begin
        if (bus.enviar) begin
          aux_n   = bus.DATO_ALU;
          i_n     = '0;
          j_n     = '0;
          state_n = CONV_H;
        end
      end
      CONV_H: begin
        if (ge_hundred) begin
          aux_n = rem_hundred;
          i_n   = I + 8'd1;
        end else begin
          state_n = CONV_T;
        end
      end
      CONV_T: begin
        if (ge_ten) begin
          aux_n = rem_ten;
          j_n   = J + 8'd1;
        end else begin
          state_n = SEND_H;
        end
      end
      SEND_H: begin
        if (!bus.fifo_full) begin
          wr_n    = 1'b1;
          data_n  = to_ascii(I);
          state_n = SEND_T;
        end
      end
      SEND_T: begin
        if (!bus.fifo_full) begin
          wr_n    = 1'b1;
          data_n  = to_ascii(J);
          state_n = SEND_U;
        end
      end
      SEND_U: begin
        if (!bus.fifo_full) begin
          wr_n    = 1'b1;
          data_n  = to_ascii(AUX);
          state_n = SEND_LF;
        end
      end
      SEND_LF: begin
        if (!bus.fifo_full) begin
          wr_n    = 1'b1;
          data_n  = ASCII_LF;
          state_n = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!bus.enviar) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output and working registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.WR_FIFO   <= 1'b0;
      bus.data_fifo <= '0;
      AUX           <= '0;
      I             <= '0;
      J             <= '0;
    end else begin
      bus.WR_FIFO   <= wr_n;
      bus.data_fifo <= data_n;
      AUX           <= aux_n;
      I             <= i_n;
      J             <= j_n;
    end
  end

endmodule

// File: tb/tb_int_tx.sv
// Bench for int_tx: requests are issued by a stimulus process that queues
// the expected ASCII bytes; a monitor pops and compares on every write.
module tb_int_tx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] STATE;
  logic [7:0] AUX;
  logic [7:0] I;
  logic [7:0] J;

  int_tx_if bus ();

  int_tx dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .STATE (STATE),
    .AUX   (AUX),
    .I     (I),
    .J     (J)
  );

  always #5 CLK = ~CLK;

  int         checks      = 0;
  int         failures    = 0;
  int         edge_cnt    = 0;
  int         write_count = 0;
  int         tx_writes   = 0;
  int         first_edge  = 0;
  logic [7:0] exp_q[$];

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Monitor: every observed write must match the head of the queue.
  always @(negedge CLK) begin
    if (!RESET && bus.WR_FIFO) begin
      write_count++;
      if (tx_writes == 0) first_edge = edge_cnt;
      tx_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'(bus.data_fifo), -1);
      end else begin
        check("wr_byte", int'(bus.data_fifo), int'(exp_q.pop_front()));
      end
    end
  end

  // One request: value, cycles enviar is held, random back-pressure, and an
  // optional 5-cycle stall forced on entering the tens-send state.
  task automatic send_byte(input logic [7:0] val, input int hold, input bit rnd_stall, input bit dir_stall);
    int  h, t, u, sample_edge, stall_left;
    bit  done, stalled, cur_dir, prev_dir, release_pending;
    h = int'(val) / 100;
    t = (int'(val) / 10) % 10;
    u = int'(val) % 10;
    @(negedge CLK);
    bus.DATO_ALU  = val;
    bus.enviar    = 1'b1;
    bus.fifo_full = 1'b0;
    exp_q.push_back(8'(8'h30 + h));
    exp_q.push_back(8'(8'h30 + t));
    exp_q.push_back(8'(8'h30 + u));
    exp_q.push_back(8'h0A);
    tx_writes   = 0;
    sample_edge = edge_cnt + 1;
    done = 0; stalled = 0; cur_dir = 0; release_pending = 0; stall_left = 0;
    for (int c = 1; c < 500 && !done; c++) begin
      @(negedge CLK);
      if (cur_dir) check("stall_no_wr", int'(bus.WR_FIFO), 0);
      if (release_pending) begin
        check("stall_release_wr", int'(bus.WR_FIFO), 1);
        check("stall_release_byte", int'(bus.data_fifo), 8'h37);
        release_pending = 0;
      end
      if (c >= hold && STATE == 3'd0 && exp_q.size() == 0) begin
        done = 1;
      end else begin
        bus.enviar   = (c < hold);
        bus.DATO_ALU = 8'($urandom_range(0, 255));
        if (dir_stall && !stalled && STATE == 3'd4) begin
          stalled    = 1;
          stall_left = 5;
        end
        prev_dir = cur_dir;
        cur_dir  = (stall_left > 0);
        if (cur_dir) stall_left--;
        if (prev_dir && !cur_dir) release_pending = 1;
        bus.fifo_full = cur_dir ? 1'b1 : (rnd_stall ? ($urandom_range(0, 2) == 0) : 1'b0);
      end
    end
    bus.fifo_full = 1'b0;
    bus.enviar    = 1'b0;
    check("tx_done", int'(done), 1);
    check("tx_writes", tx_writes, 4);
    if (dir_stall) check("stall_seen", int'(stalled), 1);
    // SEND_H is reached 2+I+J edges after the sampling edge; the registered
    // pulse becomes visible one edge later.
    if (!rnd_stall) check("first_write_latency", first_edge - sample_edge, 3 + h + t);
    check("I", int'(I), h);
    check("J", int'(J), t);
    check("AUX", int'(AUX), u);
    if (!done) exp_q.delete();
  endtask

  task automatic reset_in_conv_t();
    int wc;
    bit hit;
    @(negedge CLK);
    bus.DATO_ALU = 8'd75;
    bus.enviar   = 1'b1;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge CLK);
      if (STATE == 3'd2) hit = 1;
    end
    check("reached_conv_t", int'(hit), 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("rst_state", int'(STATE), 0);
    check("rst_wr", int'(bus.WR_FIFO), 0);
    check("rst_data", int'(bus.data_fifo), 0);
    check("rst_aux", int'(AUX), 0);
    check("rst_i", int'(I), 0);
    check("rst_j", int'(J), 0);
    @(negedge CLK);
    RESET = 1'b0;
    bus.enviar = 1'b0;
    exp_q.delete();
    wc = write_count;
    repeat (12) @(negedge CLK);
    check("no_write_after_reset", write_count - wc, 0);
    check("idle_after_reset", int'(STATE), 0);
  endtask

  initial begin
    RESET         = 1'b1;
    bus.enviar    = 1'b0;
    bus.fifo_full = 1'b0;
    bus.DATO_ALU  = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", int'(STATE), 0);
    check("reset_wr", int'(bus.WR_FIFO), 0);
    check("reset_data", int'(bus.data_fifo), 0);
    check("reset_aux", int'(AUX), 0);
    check("reset_i", int'(I), 0);
    check("reset_j", int'(J), 0);
    @(negedge CLK);
    RESET = 1'b0;

    send_byte(8'd75, 10, 0, 0);
    send_byte(8'd255, 3, 0, 0);
    send_byte(8'd0, 1, 0, 0);
    send_byte(8'd75, 10, 0, 1);
    reset_in_conv_t();
    send_byte(8'd75, 40, 0, 0);
    send_byte(8'd99, 2, 0, 0);
    send_byte(8'd100, 2, 0, 0);
    send_byte(8'd9, 2, 0, 0);
    send_byte(8'd10, 2, 0, 0);
    for (int n = 0; n < 30; n++) begin
      send_byte(8'($urandom_range(0, 255)), int'($urandom_range(1, 20)), bit'(n % 2), 1'b0);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
